// File: rtl/endnode_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : endnode_resp_ctrl
// Purpose  : Link-level response controller for an endnode. Each received
//            packet is classified at rx_packet_done into ACK / NACK / RESEND /
//            ABORT, queued in a small in-order FIFO and drained to the tx PHY
//            manager over a valid/ready handshake. Per-ID retry counters and
//            saturating CRC-fail / resend / drop statistics are maintained.
// Ports    : CLK, nRST            clock, asynchronous active-low reset
//            rx_err               per-flit error pulse for the current packet
//            rx_packet_done       1-cycle end-of-packet pulse
//            rx_crc_ok            CRC verdict, valid with rx_packet_done
//            rx_pkt_id            packet ID, valid with rx_packet_done
//            rx_buf_full          receive buffer full, valid with rx_packet_done
//            clr_cnt              synchronous clear of the statistics counters
//            tx_resp_valid/ready  response handshake towards tx manager
//            tx_resp_code/id      FIFO head (0=ACK 1=NACK 2=RESEND 3=ABORT)
//            resp_fifo_full       FIFO holds RESP_DEPTH entries
//            crc_fail_cnt         packets ended with rx_crc_ok=0
//            resend_cnt           RESEND codes actually queued
//            resp_drop_cnt        responses lost because the FIFO was full
// Revision : 1.0  initial release
// ============================================================================
module endnode_resp_ctrl #(
  parameter int NUM_IDS    = 4,
  parameter int RESP_DEPTH = 4,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_W      = 16,
  localparam int ID_W      = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             rx_err,
  input  logic             rx_packet_done,
  input  logic             rx_crc_ok,
  input  logic [ID_W-1:0]  rx_pkt_id,
  input  logic             rx_buf_full,
  input  logic             clr_cnt,
  output logic             tx_resp_valid,
  input  logic             tx_resp_ready,
  output logic [1:0]       tx_resp_code,
  output logic [ID_W-1:0]  tx_resp_id,
  output logic             resp_fifo_full,
  output logic [CNT_W-1:0] crc_fail_cnt,
  output logic [CNT_W-1:0] resend_cnt,
  output logic [CNT_W-1:0] resp_drop_cnt
);

  localparam int c_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int c_RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] c_ACK    = 2'd0;
  localparam logic [1:0] c_NACK   = 2'd1;
  localparam logic [1:0] c_RESEND = 2'd2;
  localparam logic [1:0] c_ABORT  = 2'd3;

  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = {{(c_PTR_W-1){1'b0}}, 1'b1};
  localparam logic [c_PTR_W:0]   c_CNT_ONE   = {{c_PTR_W{1'b0}}, 1'b1};
  localparam logic [c_PTR_W:0]   c_DEPTH_CNT = RESP_DEPTH[c_PTR_W:0];
  localparam logic [c_RTY_W-1:0] c_RTY_ONE   = {{(c_RTY_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   c_STAT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   c_STAT_MAX  = {CNT_W{1'b1}};

  // Registered state
  logic                  r_err_store;
  logic [c_RTY_W-1:0]    r_retry [NUM_IDS];
  logic [ID_W+1:0]       r_mem   [RESP_DEPTH];   // {code, id}
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W:0]      r_count;
  logic [CNT_W-1:0]      r_crc_fail_cnt;
  logic [CNT_W-1:0]      r_resend_cnt;
  logic [CNT_W-1:0]      r_drop_cnt;

  // Combinational
  logic                  w_err_eff;
  logic                  w_fail;
  logic                  w_retry_left;
  logic [1:0]            w_code;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_acc;
  logic                  w_drop;

  assign w_err_eff    = r_err_store | rx_err;
  assign w_fail       = w_err_eff | ~rx_crc_ok;
  assign w_retry_left = (int'(r_retry[rx_pkt_id]) + 1) < MAX_RETRY;

  always_comb begin
    w_code = c_ACK;
    if (w_fail) begin
      w_code = w_retry_left ? c_RESEND : c_ABORT;
    end else if (rx_buf_full) begin
      w_code = c_NACK;
    end
  end

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_DEPTH_CNT);
  assign w_pop      = ~w_empty & tx_resp_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_acc = rx_packet_done & (~w_full | w_pop);
  assign w_drop     = rx_packet_done & w_full & ~w_pop;

  // Sticky error: an rx_err in the done cycle is consumed by that packet.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_err_store <= 1'b0;
    end else if (rx_packet_done) begin
      r_err_store <= 1'b0;
    end else if (rx_err) begin
      r_err_store <= 1'b1;
    end
  end

  // Retry counters update on every classification, even when the response
  // itself is dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_IDS; i++) begin
        r_retry[i] <= '0;
      end
    end else if (rx_packet_done) begin
      if (w_code == c_RESEND) begin
        r_retry[rx_pkt_id] <= r_retry[rx_pkt_id] + c_RTY_ONE;
      end else begin
        r_retry[rx_pkt_id] <= '0;
      end
    end
  end

  // FIFO storage carries no reset; outputs are masked while empty.
  always_ff @(posedge CLK) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= {w_code, rx_pkt_id};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push_acc && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push_acc) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_crc_fail_cnt <= '0;
      r_resend_cnt   <= '0;
      r_drop_cnt     <= '0;
    end else if (clr_cnt) begin
      r_crc_fail_cnt <= '0;
      r_resend_cnt   <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (rx_packet_done && !rx_crc_ok && r_crc_fail_cnt != c_STAT_MAX) begin
        r_crc_fail_cnt <= r_crc_fail_cnt + c_STAT_ONE;
      end
      if (w_push_acc && w_code == c_RESEND && r_resend_cnt != c_STAT_MAX) begin
        r_resend_cnt <= r_resend_cnt + c_STAT_ONE;
      end
      if (w_drop && r_drop_cnt != c_STAT_MAX) begin
        r_drop_cnt <= r_drop_cnt + c_STAT_ONE;
      end
    end
  end

  assign tx_resp_valid  = ~w_empty;
  assign tx_resp_code   = w_empty ? 2'd0 : r_mem[r_rd_ptr][ID_W+1:ID_W];
  assign tx_resp_id     = w_empty ? '0   : r_mem[r_rd_ptr][ID_W-1:0];
  assign resp_fifo_full = w_full;
  assign crc_fail_cnt   = r_crc_fail_cnt;
  assign resend_cnt     = r_resend_cnt;
  assign resp_drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_endnode_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_endnode_resp_ctrl
// Purpose  : Self-checking bench for endnode_resp_ctrl. Directed scenarios
//            followed by randomized traffic, all compared every cycle against
//            a queue-based reference model of the response rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_endnode_resp_ctrl;

  localparam int NIDS  = 4;
  localparam int DEPTH = 4;
  localparam int MAXR  = 3;
  localparam int CW    = 4;
  localparam int IDW   = 2;
  localparam int SAT   = (1 << CW) - 1;

  logic           CLK = 1'b0;
  logic           nRST;
  logic           rx_err, rx_packet_done, rx_crc_ok, rx_buf_full, clr_cnt;
  logic [IDW-1:0] rx_pkt_id;
  logic           tx_resp_valid, tx_resp_ready, resp_fifo_full;
  logic [1:0]     tx_resp_code;
  logic [IDW-1:0] tx_resp_id;
  logic [CW-1:0]  crc_fail_cnt, resend_cnt, resp_drop_cnt;

  endnode_resp_ctrl #(
    .NUM_IDS    (NIDS),
    .RESP_DEPTH (DEPTH),
    .MAX_RETRY  (MAXR),
    .CNT_W      (CW)
  ) u_dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .rx_err         (rx_err),
    .rx_packet_done (rx_packet_done),
    .rx_crc_ok      (rx_crc_ok),
    .rx_pkt_id      (rx_pkt_id),
    .rx_buf_full    (rx_buf_full),
    .clr_cnt        (clr_cnt),
    .tx_resp_valid  (tx_resp_valid),
    .tx_resp_ready  (tx_resp_ready),
    .tx_resp_code   (tx_resp_code),
    .tx_resp_id     (tx_resp_id),
    .resp_fifo_full (resp_fifo_full),
    .crc_fail_cnt   (crc_fail_cnt),
    .resend_cnt     (resend_cnt),
    .resp_drop_cnt  (resp_drop_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int q_code[$];
  int q_id[$];
  int m_retry[NIDS];
  int m_crc, m_res, m_drop;
  bit m_err;

  int n_vec;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    q_code.delete();
    q_id.delete();
    for (int i = 0; i < NIDS; i++) m_retry[i] = 0;
    m_crc = 0; m_res = 0; m_drop = 0; m_err = 1'b0;
  endtask

  task automatic check_all();
    bit v;
    v = (q_code.size() != 0);
    chk("valid", tx_resp_valid, v);
    chk("code",  tx_resp_code,  v ? q_code[0] : 0);
    chk("id",    tx_resp_id,    v ? q_id[0]   : 0);
    chk("full",  resp_fifo_full, q_code.size() == DEPTH);
    chk("crc_fail_cnt",  crc_fail_cnt,  m_crc);
    chk("resend_cnt",    resend_cnt,    m_res);
    chk("resp_drop_cnt", resp_drop_cnt, m_drop);
  endtask

  // One clock cycle: drive inputs, advance the model, then compare.
  task automatic cyc(input bit pd, input bit er, input bit crc, input int id,
                     input bit bf, input bit rdy, input bit clr);
    bit pop, fail;
    int code;
    @(negedge CLK);
    rx_packet_done = pd; rx_err = er; rx_crc_ok = crc;
    rx_pkt_id = IDW'(id); rx_buf_full = bf; tx_resp_ready = rdy; clr_cnt = clr;

    pop = (q_code.size() != 0) && rdy;
    if (pd) begin
      fail = m_err || er || !crc;
      if (fail) begin
        if (m_retry[id] + 1 < MAXR) begin
          code = 2; m_retry[id]++;
        end else begin
          code = 3; m_retry[id] = 0;
        end
      end else begin
        code = bf ? 1 : 0;
        m_retry[id] = 0;
      end
      if (!crc) m_crc = sat_inc(m_crc);
      if (pop) begin
        void'(q_code.pop_front()); void'(q_id.pop_front());
      end
      if (q_code.size() < DEPTH) begin
        q_code.push_back(code); q_id.push_back(id);
        if (code == 2) m_res = sat_inc(m_res);
      end else begin
        m_drop = sat_inc(m_drop);
      end
      m_err = 1'b0;
    end else begin
      if (er) m_err = 1'b1;
      if (pop) begin
        void'(q_code.pop_front()); void'(q_id.pop_front());
      end
    end
    if (clr) begin
      m_crc = 0; m_res = 0; m_drop = 0;
    end

    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 1'b0, 1'b1, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic pkt(input bit er, input bit crc, input int id, input bit bf, input bit rdy);
    cyc(1'b1, er, crc, id, bf, rdy, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    nRST = 1'b0;
    rx_err = 1'b0; rx_packet_done = 1'b0; rx_crc_ok = 1'b1; rx_pkt_id = '0;
    rx_buf_full = 1'b0; clr_cnt = 1'b0; tx_resp_ready = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_all();
    nRST = 1'b1;

    // Good packet -> ACK next cycle, popped by ready
    pkt(0, 1, 2, 0, 0);
    chk("t1_valid", tx_resp_valid, 1);
    chk("t1_code",  tx_resp_code, 0);
    chk("t1_id",    tx_resp_id, 2);
    idle(1);
    chk("t1_popped", tx_resp_valid, 0);

    // Error pulse 3 cycles before done -> RESEND, then clean -> ACK
    cyc(0, 1, 1, 0, 0, 1, 0);
    idle(1);
    idle(1);
    pkt(0, 1, 1, 0, 1);
    chk("t2_code", tx_resp_code, 2);
    chk("t2_resend", resend_cnt, 1);
    idle(1);
    pkt(0, 1, 1, 0, 1);
    chk("t2_ack", tx_resp_code, 0);
    idle(1);

    // Retry limit on id 3
    cyc(0, 0, 1, 0, 0, 1, 1);
    pkt(0, 0, 3, 0, 1);
    chk("t3_r1", tx_resp_code, 2);
    pkt(0, 0, 3, 0, 1);
    chk("t3_r2", tx_resp_code, 2);
    pkt(0, 0, 3, 0, 1);
    chk("t3_abort", tx_resp_code, 3);
    chk("t3_crc", crc_fail_cnt, 3);
    chk("t3_res", resend_cnt, 2);
    pkt(0, 0, 3, 0, 1);
    chk("t3_r4", tx_resp_code, 2);
    idle(1);

    // Overflow: 5 packets, ready low
    cyc(0, 0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) pkt(0, 1, i % NIDS, 0, 0);
    chk("t4_full", resp_fifo_full, 1);
    chk("t4_drop", resp_drop_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", tx_resp_id, i);
      idle(1);
    end
    chk("t4_empty", tx_resp_valid, 0);
    for (int i = 0; i < 4; i++) pkt(0, 1, i, 1, 0);
    pkt(0, 1, 1, 0, 1);
    chk("t4_pp_drop", resp_drop_cnt, 1);
    chk("t4_pp_full", resp_fifo_full, 1);
    for (int i = 0; i < 4; i++) idle(1);

    // Counter saturation and clear priority
    cyc(0, 0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) pkt(0, 0, i % NIDS, 0, 1);
    chk("t5_sat", crc_fail_cnt, SAT);
    cyc(1, 0, 0, 0, 0, 1, 1);
    chk("t5_clr", crc_fail_cnt, 0);
    idle(1);
    idle(1);

    // Asynchronous reset with queued responses
    for (int i = 0; i < 3; i++) pkt(0, 1, i, 0, 0);
    chk("t6_queued", tx_resp_valid, 1);
    cyc(0, 1, 1, 0, 0, 0, 0);   // leave a pending error that reset must clear
    #2 nRST = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", tx_resp_valid, 0);
    check_all();
    @(negedge CLK);
    rx_err = 1'b0; rx_packet_done = 1'b0; tx_resp_ready = 1'b0; clr_cnt = 1'b0;
    nRST = 1'b1;
    pkt(0, 1, 0, 0, 1);
    chk("t6_ack", tx_resp_code, 0);
    chk("t6_valid", tx_resp_valid, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int rdy_pct;
      rdy_pct = (i < 400) ? 30 : 80;
      cyc($urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 70,
          int'($urandom_range(0, NIDS - 1)),
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < rdy_pct,
          $urandom_range(0, 99) < 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
